mem_io_responder: RTL and testbench

Responder end of the CPU's byte-wide memory bus. It serves RAM reads and writes with the CPU's timing contract: reads return data the next cycle, writes commit in one cycle. It also decodes the I/O window at `a[17:16]==2'b11`, which holds UART RX/TX byte FIFOs, a free-running cycle counter and a program-stop flag. It sits between the CPU top and the UART/host link, and its `rdy_out` drives the CPU's `rdy_in`.

---
 rtl/mem_io_responder_if.sv | 11 +
 rtl/mem_io_responder.sv | 130 +++++++++++++
 tb/tb_mem_io_responder.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// CPU-side byte bus between the CPU core and mem_io_responder.
interface mem_io_responder_if;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        rdy_out;

    modport master (output cpu_a, cpu_wr, cpu_dout, input cpu_din, rdy_out);
    modport slave  (input cpu_a, cpu_wr, cpu_dout, output cpu_din, rdy_out);
endinterface

// File: rtl/mem_io_responder.sv
// Byte-wide RAM responder with an I/O window at a[17:16]==2'b11 (UART FIFOs, cycle counter, stop flag).
// Optional COUNTER_SNAPSHOT_EN: reading 0x30004 freezes the counter so 0x30005-0x30007 read a coherent dword.
module mem_io_responder #(
    parameter int unsigned RAM_ADDR_W   = 17,
    parameter int unsigned FIFO_DEPTH_W = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mem_io_responder_if.slave bus,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              program_stop
);
    localparam int unsigned DEPTH     = 1 << FIFO_DEPTH_W;
    localparam int unsigned PTR_W     = FIFO_DEPTH_W + 1;
    localparam int unsigned RAM_WORDS = 1 << RAM_ADDR_W;

    logic [7:0]            ram    [RAM_WORDS];
    logic [7:0]            rx_mem [DEPTH];
    logic [7:0]            tx_mem [DEPTH];
    logic [PTR_W-1:0]      rx_wp, rx_rp, tx_wp, tx_rp;
    logic [31:0]           cnt;
    logic [31:0]           cnt_src;
    logic [7:0]            din_q;
    logic [7:0]            tx_wdata;
    logic [7:0]            rd_byte;
    logic [RAM_ADDR_W-1:0] idx;
    logic [15:0]           off;
    logic                  io, sel_data, sel_cnt, sel_c4;
    logic                  rx_empty, rx_full, tx_empty, tx_full;
    logic                  rx_req, tx_req, rdy;
    logic                  rx_push, rx_pop, tx_push, tx_pop, ram_we;
    logic                  unused_addr;

    assign idx         = bus.cpu_a[RAM_ADDR_W-1:0];
    assign off         = bus.cpu_a[15:0];
    assign io          = (bus.cpu_a[17:16] == 2'b11);
    assign unused_addr = &{1'b0, bus.cpu_a[31:18]};

    assign sel_data = io && (off == 16'h0000);
    assign sel_cnt  = io && (off[15:2] == 14'h0001);
    assign sel_c4   = io && (off == 16'h0004);

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[FIFO_DEPTH_W-1:0] == rx_rp[FIFO_DEPTH_W-1:0]) &&
                      (rx_wp[FIFO_DEPTH_W] != rx_rp[FIFO_DEPTH_W]);
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[FIFO_DEPTH_W-1:0] == tx_rp[FIFO_DEPTH_W-1:0]) &&
                      (tx_wp[FIFO_DEPTH_W] != tx_rp[FIFO_DEPTH_W]);

    // Bus pushes into TX: non-zero data bytes, plus the 0x00 terminator of the stop write.
    assign tx_req = bus.cpu_wr && !program_stop &&
                    ((sel_data && (bus.cpu_dout != 8'h00)) || sel_c4);
    assign rx_req = !bus.cpu_wr && sel_data;

    assign tx_valid = !rst_in && !tx_empty;
    assign tx_data  = rst_in ? 8'h00 : tx_mem[tx_rp[FIFO_DEPTH_W-1:0]];
    assign rx_ready = !rst_in && !rx_full;
    assign tx_pop   = tx_valid && tx_ready;
    assign rx_push  = rx_valid && rx_ready;

    // A full TX FIFO still takes the bus push when the link pops it in the same cycle.
    assign rdy         = !rst_in && !(rx_req && rx_empty) && !(tx_req && tx_full && !tx_pop);
    assign bus.rdy_out = rdy;
    assign bus.cpu_din = din_q;

    assign rx_pop   = rdy && rx_req;
    assign tx_push  = rdy && tx_req;
    assign tx_wdata = sel_c4 ? 8'h00 : bus.cpu_dout;
    assign ram_we   = rdy && bus.cpu_wr && !io && !program_stop;

`ifdef COUNTER_SNAPSHOT_EN
    logic [31:0] snap;

    // Byte 0 reads live; the upper bytes come from the value frozen by that read.
    assign cnt_src = (off[1:0] == 2'b00) ? cnt : snap;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            snap <= 32'h0;
        end else if (rdy && !bus.cpu_wr && sel_c4) begin
            snap <= cnt;
        end
    end
`else
    assign cnt_src = cnt;
`endif

    always_comb begin
        rd_byte = 8'h00;
        if (!io) begin
            rd_byte = ram[idx];
        end else if (sel_data) begin
            rd_byte = rx_mem[rx_rp[FIFO_DEPTH_W-1:0]];
        end else if (sel_cnt) begin
            rd_byte = 8'(cnt_src >> {off[1:0], 3'b000});
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt          <= 32'h0;
            rx_wp        <= '0;
            rx_rp        <= '0;
            tx_wp        <= '0;
            tx_rp        <= '0;
            din_q        <= 8'h00;
            program_stop <= 1'b0;
        end else begin
            cnt <= cnt + 32'd1;
            if (rdy && !bus.cpu_wr) din_q <= rd_byte;
            if (rx_push) rx_wp <= rx_wp + PTR_W'(1);
            if (rx_pop)  rx_rp <= rx_rp + PTR_W'(1);
            if (tx_push) tx_wp <= tx_wp + PTR_W'(1);
            if (tx_pop)  tx_rp <= tx_rp + PTR_W'(1);
            if (rdy && bus.cpu_wr && sel_c4) program_stop <= 1'b1;
        end
    end

    // Storage arrays carry no reset; push/write enables are already low during reset.
    always_ff @(posedge clk_in) begin
        if (ram_we)  ram[idx] <= bus.cpu_dout;
        if (rx_push) rx_mem[rx_wp[FIFO_DEPTH_W-1:0]] <= rx_data;
        if (tx_push) tx_mem[tx_wp[FIFO_DEPTH_W-1:0]] <= tx_wdata;
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: vector table for RAM/decode, hand sequences for stalls, stop and reset.
module tb_mem_io_responder;
    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic        exp_rdy;
        logic        chk;
        logic [7:0]  exp_din;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        program_stop;
    logic [31:0] mcnt;
    logic [7:0]  got [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mem_io_responder_if bus ();

    mem_io_responder dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .bus          (bus),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .program_stop (program_stop)
    );

    // Reference cycle counter: cleared by each reset edge, +1 on every other edge.
    always @(posedge clk) mcnt <= rst ? 32'd0 : mcnt + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
        bus.cpu_wr   = wr;
        bus.cpu_a    = a;
        bus.cpu_dout = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_tx();
        got.delete();
        drive(1'b0, 32'h0, 8'h00);
        tx_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (tx_valid) got.push_back(tx_data);
        end
        step();
        tx_ready = 1'b0;
    endtask

    task automatic check_tx(input string name, input logic [7:0] e [$]);
        check({name, "_count"}, 32'(got.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++)
            check($sformatf("%s_%0d", name, i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(e[i]));
    endtask

    task automatic add(input logic wr, input logic [31:0] a, input logic [7:0] d,
                       input logic chk, input logic [7:0] exp_din, input string name,
                       inout vec_t vt [$]);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.exp_rdy = 1'b1;
        v.chk = chk; v.exp_din = exp_din; v.name = name;
        vt.push_back(v);
    endtask

    initial begin
        vec_t        vt [$];
        logic [7:0]  exp_q [$];
        logic [7:0]  exp_cnt [4];
        int          guard;

        // 1: wr, a, d, chk, exp_din
        add(1, 32'h0000_0123, 8'hA5, 0, 8'h00, "ram_wr_a5",    vt);
        add(0, 32'h0000_0123, 8'h00, 1, 8'hA5, "ram_rd_a5",    vt);
        add(1, 32'h0001_FFFF, 8'h3C, 0, 8'h00, "ram_wr_top",   vt);
        add(0, 32'h0001_FFFF, 8'h00, 1, 8'h3C, "ram_rd_top",   vt);
        add(0, 32'h0002_0123, 8'h00, 1, 8'hA5, "ram_alias",    vt);
        add(0, 32'h8001_FFFF, 8'h00, 1, 8'h3C, "ram_alias_hi", vt);
        add(1, 32'h0000_0000, 8'h11, 0, 8'h00, "ram_wr_0",     vt);
        add(1, 32'h0000_ABCD, 8'h6E, 0, 8'h00, "ram_wr_abcd",  vt);
        add(1, 32'h0001_0010, 8'h55, 0, 8'h00, "ram_wr_10010", vt);
        add(0, 32'h0001_0010, 8'h00, 1, 8'h55, "ram_rd_10010", vt);
        add(1, 32'h0003_0010, 8'h77, 1, 8'h55, "io_wr_hold",   vt);
        add(0, 32'h0001_0010, 8'h00, 1, 8'h55, "io_wr_no_ram", vt);
        add(0, 32'h0003_0010, 8'h00, 1, 8'h00, "io_rd_unmap",  vt);
        add(0, 32'h0000_0000, 8'h00, 1, 8'h11, "ram_rd_0",     vt);
        add(0, 32'h0003_0002, 8'h00, 1, 8'h00, "io_rd_30002",  vt);
        add(1, 32'h0003_0000, 8'h00, 0, 8'h00, "tx_wr_zero",   vt);

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        drive(1'b0, 32'h0, 8'h00);
        step(); step();
        @(negedge clk);
        check("rst_rdy",      32'(bus.rdy_out),  0);
        check("rst_rx_ready", 32'(rx_ready),     0);
        check("rst_tx_valid", 32'(tx_valid),     0);
        check("rst_tx_data",  32'(tx_data),      0);
        check("rst_stop",     32'(program_stop), 0);
        check("rst_din",      32'(bus.cpu_din),  0);
        step();
        rst = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].wr, vt[i].a, vt[i].d);
            @(negedge clk);
            check({vt[i].name, "_rdy"}, 32'(bus.rdy_out), 32'(vt[i].exp_rdy));
            step();
            if (vt[i].chk) check(vt[i].name, 32'(bus.cpu_din), 32'(vt[i].exp_din));
        end
        check("tx_zero_ignored", 32'(tx_valid), 0);

        // TX: one byte, fill to 8, 9th write stalls until a one-cycle tx_ready pulse.
        drive(1'b1, 32'h3_0000, 8'h48);
        step();
        check("tx_valid_48", 32'(tx_valid), 1);
        check("tx_data_48",  32'(tx_data),  32'h48);
        for (int k = 1; k <= 7; k++) begin
            drive(1'b1, 32'h3_0000, 8'(k));
            @(negedge clk);
            check($sformatf("tx_fill_rdy_%0d", k), 32'(bus.rdy_out), 1);
            step();
        end
        drive(1'b1, 32'h3_0000, 8'h09);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("tx_full_stall", 32'(bus.rdy_out), 0);
            step();
        end
        tx_ready = 1'b1;
        @(negedge clk);
        check("tx_pop_push_rdy", 32'(bus.rdy_out), 1);
        check("tx_pop_head",     32'(tx_data),     32'h48);
        step();
        tx_ready = 1'b0;
        drive(1'b0, 32'h0, 8'h00);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09};
        drain_tx();
        check_tx("tx_drain", exp_q);
        check("tx_empty", 32'(tx_valid), 0);

        // RX stall on empty FIFO, then a byte arrives.
        drive(1'b0, 32'h3_0000, 8'h00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rx_stall_rdy", 32'(bus.rdy_out), 0);
            step();
            check("rx_stall_din_hold", 32'(bus.cpu_din), 32'h11);
        end
        rx_valid = 1'b1; rx_data = 8'h41;
        @(negedge clk);
        check("rx_push_rdy",   32'(bus.rdy_out), 0);
        check("rx_push_ready", 32'(rx_ready),    1);
        step();
        rx_valid = 1'b0;
        @(negedge clk);
        check("rx_pop_rdy", 32'(bus.rdy_out), 1);
        step();
        check("rx_pop_din", 32'(bus.cpu_din), 32'h41);
        @(negedge clk);
        check("rx_empty_again", 32'(bus.rdy_out), 0);
        step();

        // RX full: fullness is judged before a simultaneous bus pop.
        drive(1'b0, 32'h0, 8'h00);
        rx_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rx_data = 8'hA0 + 8'(k);
            @(negedge clk);
            check("rx_fill_ready", 32'(rx_ready), 1);
            step();
        end
        rx_data = 8'hEE;
        drive(1'b0, 32'h3_0000, 8'h00);
        @(negedge clk);
        check("rx_full_ready", 32'(rx_ready),    0);
        check("rx_full_rdy",   32'(bus.rdy_out), 1);
        step();
        rx_valid = 1'b0;
        check("rx_full_pop0", 32'(bus.cpu_din), 32'hA0);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            check("rx_drain_rdy", 32'(bus.rdy_out), 1);
            step();
            check($sformatf("rx_drain_%0d", k), 32'(bus.cpu_din), 32'(8'hA0 + 8'(k)));
        end
        @(negedge clk);
        check("rx_full_no_push", 32'(bus.rdy_out), 0);
        step();

        // Reset during an RX stall with a TX byte pending.
        drive(1'b1, 32'h3_0000, 8'h5A);
        step();
        drive(1'b0, 32'h3_0000, 8'h00);
        @(negedge clk);
        check("mid_stall_rdy", 32'(bus.rdy_out), 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rdy",      32'(bus.rdy_out), 0);
        check("mid_rst_rx_ready", 32'(rx_ready),    0);
        check("mid_rst_tx_valid", 32'(tx_valid),    0);
        check("mid_rst_tx_data",  32'(tx_data),     0);
        step();
        check("mid_rst_din", 32'(bus.cpu_din), 0);
        rst = 1'b0;
        drive(1'b0, 32'h3_0004, 8'h00);
        @(negedge clk);
        check("post_rst_rdy",      32'(bus.rdy_out), 1);
        check("post_rst_tx_empty", 32'(tx_valid),    0);
        step();
        check("post_rst_cnt0", 32'(bus.cpu_din), 0);
        drive(1'b0, 32'h0_ABCD, 8'h00);
        step();
        check("post_rst_ram", 32'(bus.cpu_din), 32'h6E);
        drive(1'b0, 32'h3_0000, 8'h00);
        @(negedge clk);
        check("post_rst_rx_empty", 32'(bus.rdy_out), 0);
        step();

        // Stop: pending 0x21, stop write queues 0x00, later writes are ignored.
        drive(1'b1, 32'h0_0200, 8'h12);
        step();
        drive(1'b1, 32'h3_0000, 8'h21);
        step();
        drive(1'b1, 32'h3_0004, 8'hEE);
        @(negedge clk);
        check("stop_wr_rdy",    32'(bus.rdy_out),  1);
        check("stop_before",    32'(program_stop), 0);
        step();
        check("stop_set", 32'(program_stop), 1);
        drive(1'b1, 32'h0_0200, 8'h99);
        step();
        drive(1'b1, 32'h3_0000, 8'h33);
        @(negedge clk);
        check("stop_tx_wr_rdy", 32'(bus.rdy_out), 1);
        step();
        drive(1'b0, 32'h0_0200, 8'h00);
        step();
        check("stop_ram_ignored", 32'(bus.cpu_din), 32'h12);
        exp_q = '{8'h21, 8'h00};
        drain_tx();
        check_tx("stop_tx", exp_q);
        check("stop_sticky", 32'(program_stop), 1);

        // Counter: reset, then read the four bytes starting at count 0x000100FF.
        rst = 1'b1;
        step(); step();
        check("cnt_rst_stop", 32'(program_stop), 0);
        rst = 1'b0;
        guard = 0;
        while (mcnt != 32'h0001_00FF && guard < 70000) begin
            step();
            guard++;
        end
        if (mcnt != 32'h0001_00FF) begin
            n_tests++;
            n_fail++;
            $display("FAIL cnt_wait: count 0x%0h, required 0x100ff", mcnt);
        end
`ifdef COUNTER_SNAPSHOT_EN
        exp_cnt = '{8'hFF, 8'h00, 8'h01, 8'h00};
`else
        exp_cnt = '{8'hFF, 8'h01, 8'h01, 8'h00};
`endif
        for (int b = 0; b < 4; b++) begin
            drive(1'b0, 32'h3_0004 + 32'(b), 8'h00);
            step();
            check($sformatf("cnt_byte_%0d", b), 32'(bus.cpu_din), 32'(exp_cnt[b]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not complete, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end
endmodule
